// File: rtl/led_pkg.sv
// led_pkg
// Shared definitions for the LED sweep engine: sweep modes, engine states
// and the BOUNCE direction flag.
// No ports; imported by led_chaser_if, led_chaser and led_tick_gen.
package led_pkg;

    // Sweep modes as seen on the mode input.
    typedef enum logic [1:0] {
        MODE_RIGHT  = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    // Engine states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Travel direction of the segment while bouncing.
    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

endpackage

// File: rtl/led_chaser_if.sv
// led_chaser_if
// Control/status bundle between the LED sequencer (master) and one
// led_chaser sweep engine (slave).
// Signals: start, mode, div, enable, abort, loop (master -> slave);
//          out, busy, last, done (slave -> master).
interface led_chaser_if
    import led_pkg::*;
#(
    parameter int N_LEDS = 18,
    parameter int DIV_W  = 8
);
    logic              start;
    mode_e             mode;
    logic [DIV_W-1:0]  div;
    logic              enable;
    logic              abort;
    logic              loop;
    logic [N_LEDS-1:0] out;
    logic              busy;
    logic              last;
    logic              done;

    modport master (
        output start, mode, div, enable, abort, loop,
        input  out, busy, last, done
    );

    modport slave (
        input  start, mode, div, enable, abort, loop,
        output out, busy, last, done
    );
endinterface

// File: rtl/led_tick_gen.sv
// led_tick_gen
// Step-rate divider. Counts 0..div while run is high and fires tick on the
// cycle the count equals div, after which the count wraps to 0.
// Ports: clk, localReset (async, active-high), run (count enable),
//        clear (force count to 0), div (terminal count), tick (step strobe).
module led_tick_gen
    import led_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             localReset,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    assign tick = run && (count_q == div);

    // Clear wins over counting so a new or reloaded sweep always starts
    // its first position with a full period.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            if (count_q == div) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge localReset) begin
        if (localReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_chaser.sv
// led_chaser
// Parametrised LED sweep engine: moves a SEG_W-wide lit segment across an
// N_LEDS-wide bar in RIGHT, LEFT, BOUNCE or FILL mode, one position per
// divider tick, with pause, abort and auto-repeat.
// Ports: clk, localReset (async, active-high),
//        bus (led_chaser_if.slave: start/mode/div/enable/abort/loop in,
//             out/busy/last/done out).
module led_chaser
    import led_pkg::*;
#(
    parameter int N_LEDS = 18,
    parameter int SEG_W  = 2,
    parameter int DIV_W  = 8
) (
    input  logic         clk,
    input  logic         localReset,
    led_chaser_if.slave  bus
);

    localparam logic [N_LEDS-1:0] LSB_SEG = {{(N_LEDS-SEG_W){1'b0}}, {SEG_W{1'b1}}};
    localparam logic [N_LEDS-1:0] MSB_SEG = {{SEG_W{1'b1}}, {(N_LEDS-SEG_W){1'b0}}};
    localparam logic [N_LEDS-1:0] ALL_ON  = {N_LEDS{1'b1}};

    state_e            state_q, state_d;
    logic [N_LEDS-1:0] out_q, out_d;
    mode_e             mode_q, mode_d;
    logic [DIV_W-1:0]  div_q, div_d;
    dir_e              dir_q, dir_d;

    logic tick;
    logic clear;
    logic runEn;
    logic atFinal;
    logic startAcc;
    logic endOfSweep;

    function automatic logic [N_LEDS-1:0] initPattern(input mode_e m);
        case (m)
            MODE_LEFT: return LSB_SEG;
            MODE_FILL: return '0;
            default:   return MSB_SEG;
        endcase
    endfunction

    // A bounce is only finished once it has turned round and climbed back
    // to the top, hence the direction qualifier.
    always_comb begin
        atFinal = 1'b0;
        case (mode_q)
            MODE_RIGHT:  atFinal = (out_q == LSB_SEG);
            MODE_LEFT:   atFinal = (out_q == MSB_SEG);
            MODE_BOUNCE: atFinal = (out_q == MSB_SEG) && (dir_q == DIR_LEFT);
            MODE_FILL:   atFinal = (out_q == ALL_ON);
            default:     atFinal = 1'b0;
        endcase
    end

    assign runEn      = (state_q == RUN) && bus.enable;
    assign startAcc   = (state_q == IDLE) && bus.start && !bus.abort;
    assign endOfSweep = (state_q == RUN) && tick && atFinal && !bus.abort;
    assign clear      = bus.abort || startAcc || (endOfSweep && bus.loop);

    led_tick_gen #(
        .DIV_W(DIV_W)
    ) u_tickGen (
        .clk       (clk),
        .localReset(localReset),
        .run       (runEn),
        .clear     (clear),
        .div       (div_q),
        .tick      (tick)
    );

    // Next-state logic. Abort beats both the tick and a start arriving in
    // the same cycle; mode and div are only captured on an accepted start.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        mode_d  = mode_q;
        div_d   = div_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                out_d = '0;
                if (startAcc) begin
                    state_d = RUN;
                    mode_d  = bus.mode;
                    div_d   = bus.div;
                    dir_d   = DIR_RIGHT;
                    out_d   = initPattern(bus.mode);
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    out_d   = '0;
                end else if (endOfSweep) begin
                    dir_d = DIR_RIGHT;
                    if (bus.loop) begin
                        out_d = initPattern(mode_q);
                    end else begin
                        state_d = IDLE;
                        out_d   = '0;
                    end
                end else if (tick) begin
                    case (mode_q)
                        MODE_RIGHT: out_d = out_q >> 1;
                        MODE_LEFT:  out_d = out_q << 1;
                        MODE_BOUNCE: begin
                            // Turn round on the bottom position so it is
                            // shown only once.
                            if (dir_q == DIR_RIGHT && out_q == LSB_SEG) begin
                                dir_d = DIR_LEFT;
                                out_d = out_q << 1;
                            end else if (dir_q == DIR_RIGHT) begin
                                out_d = out_q >> 1;
                            end else begin
                                out_d = out_q << 1;
                            end
                        end
                        MODE_FILL:  out_d = {1'b1, out_q[N_LEDS-1:1]};
                        default:    out_d = out_q;
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge localReset) begin
        if (localReset) begin
            state_q <= IDLE;
            out_q   <= '0;
            mode_q  <= MODE_RIGHT;
            div_q   <= '0;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = (state_q == RUN);
    assign bus.last = (state_q == RUN) && atFinal;
    assign bus.done = endOfSweep;

endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser
// Scoreboard bench for led_chaser (N_LEDS=18, SEG_W=2). Stimulus pushes the
// expected out/last/done for every busy cycle of a sweep into a queue; a
// monitor pops and compares on each falling edge while busy is high.
module tb_led_chaser;
    import led_pkg::*;

    localparam int N_LEDS = 18;
    localparam int SEG_W  = 2;
    localparam int DIV_W  = 8;

    typedef struct packed {
        logic [N_LEDS-1:0] out;
        logic              last;
        logic              done;
    } exp_t;

    logic clk = 1'b0;
    logic localReset;
    int   checks = 0;
    int   failures = 0;
    int   stepNo = 0;
    exp_t expQ[$];

    led_chaser_if #(.N_LEDS(N_LEDS), .DIV_W(DIV_W)) bus ();

    led_chaser #(
        .N_LEDS(N_LEDS),
        .SEG_W (SEG_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .localReset(localReset),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Hand-derived pattern for position i of a sweep on an 18-LED bar.
    function automatic logic [N_LEDS-1:0] expPattern(input mode_e m, input int i);
        logic [N_LEDS-1:0] msb;
        logic [N_LEDS-1:0] lsb;
        logic [N_LEDS-1:0] all;
        msb = 18'h30000;
        lsb = 18'h00003;
        all = 18'h3FFFF;
        case (m)
            MODE_RIGHT:  return msb >> i;
            MODE_LEFT:   return lsb << i;
            MODE_BOUNCE: return (i <= 16) ? (msb >> i) : (lsb << (i - 16));
            default:     return ~(all >> i);
        endcase
    endfunction

    function automatic int positions(input mode_e m);
        case (m)
            MODE_BOUNCE: return 33;
            MODE_FILL:   return 19;
            default:     return 17;
        endcase
    endfunction

    task automatic pushSweep(input mode_e m, input int divv);
        exp_t e;
        int   np;
        np = positions(m);
        for (int p = 0; p < np; p++) begin
            for (int c = 0; c <= divv; c++) begin
                e.out  = expPattern(m, p);
                e.last = (p == np - 1);
                e.done = (p == np - 1) && (c == divv);
                expQ.push_back(e);
            end
        end
    endtask

    task automatic pushItem(input logic [N_LEDS-1:0] o);
        exp_t e;
        e.out  = o;
        e.last = 1'b0;
        e.done = 1'b0;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input mode_e m, input logic [DIV_W-1:0] d, input logic lp);
        @(posedge clk);
        #1;
        bus.mode  = m;
        bus.div   = d;
        bus.loop  = lp;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [N_LEDS-1:0] eOut,
                               input logic eBusy, input logic eLast, input logic eDone);
        checks++;
        if (bus.out !== eOut || bus.busy !== eBusy || bus.last !== eLast || bus.done !== eDone) begin
            failures++;
            $display("[TB] FAIL %s: out=%h busy=%b last=%b done=%b, expected out=%h busy=%b last=%b done=%b",
                     name, bus.out, bus.busy, bus.last, bus.done, eOut, eBusy, eLast, eDone);
        end
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s: %0d expected steps never seen, expected 0 left", name, expQ.size());
            expQ.delete();
        end
    endtask

    // Monitor: every busy cycle must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                stepNo++;
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL step%0d: busy=1 out=%h, expected idle", stepNo, bus.out);
                end else begin
                    e = expQ.pop_front();
                    if (bus.out !== e.out || bus.last !== e.last || bus.done !== e.done) begin
                        failures++;
                        $display("[TB] FAIL step%0d: out=%h last=%b done=%b, expected out=%h last=%b done=%b",
                                 stepNo, bus.out, bus.last, bus.done, e.out, e.last, e.done);
                    end
                end
            end
        end
    end

    initial begin
        bus.start  = 1'b0;
        bus.mode   = MODE_RIGHT;
        bus.div    = '0;
        bus.enable = 1'b1;
        bus.abort  = 1'b0;
        bus.loop   = 1'b0;
        localReset = 1'b1;
        #1;
        checkOutput("resetAsync", '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        localReset = 1'b0;
        @(negedge clk);
        checkOutput("resetIdle", '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] RIGHT div=0");
        pushSweep(MODE_RIGHT, 0);
        applyStimulus(MODE_RIGHT, 8'd0, 1'b0);
        waitDrain("rightDrain", 40);
        @(negedge clk);
        checkOutput("rightIdle", '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] LEFT div=3");
        pushSweep(MODE_LEFT, 3);
        applyStimulus(MODE_LEFT, 8'd3, 1'b0);
        waitDrain("leftDrain", 120);
        @(negedge clk);
        checkOutput("leftIdle", '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] BOUNCE div=0");
        pushSweep(MODE_BOUNCE, 0);
        applyStimulus(MODE_BOUNCE, 8'd0, 1'b0);
        waitDrain("bounceDrain", 60);
        @(negedge clk);
        checkOutput("bounceIdle", '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] FILL div=0 loop");
        pushSweep(MODE_FILL, 0);
        pushSweep(MODE_FILL, 0);
        pushSweep(MODE_FILL, 0);
        applyStimulus(MODE_FILL, 8'd0, 1'b1);
        repeat (45) @(posedge clk);
        #1;
        bus.loop = 1'b0;
        waitDrain("fillDrain", 40);
        @(negedge clk);
        checkOutput("fillIdle", '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] RIGHT pause then abort");
        pushItem(18'h30000);
        pushItem(18'h18000);
        pushItem(18'h0C000);
        for (int k = 0; k < 6; k++) pushItem(18'h06000);
        pushItem(18'h03000);
        pushItem(18'h01800);
        pushItem(18'h00C00);
        applyStimulus(MODE_RIGHT, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus.enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        waitDrain("pauseDrain", 5);
        @(negedge clk);
        checkOutput("abortIdle", '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] start while busy, reset mid-sweep");
        pushItem(18'h30000);
        pushItem(18'h18000);
        pushItem(18'h0C000);
        pushItem(18'h06000);
        pushItem(18'h03000);
        applyStimulus(MODE_RIGHT, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.mode  = MODE_LEFT;
        bus.div   = 8'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode  = MODE_RIGHT;
        bus.div   = 8'd0;
        repeat (2) @(posedge clk);
        #3;
        localReset = 1'b1;
        #1;
        checkOutput("resetMidSweep", '0, 1'b0, 1'b0, 1'b0);
        waitDrain("preResetDrain", 2);
        @(posedge clk);
        #1;
        localReset = 1'b0;
        @(negedge clk);
        checkOutput("postResetIdle", '0, 1'b0, 1'b0, 1'b0);
        pushSweep(MODE_RIGHT, 0);
        applyStimulus(MODE_RIGHT, 8'd0, 1'b0);
        waitDrain("cleanDrain", 40);
        @(negedge clk);
        checkOutput("cleanIdle", '0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
